// File: rtl/fp_result_sink.sv
// fp_result_sink
//   Downstream stage of the FP multiplier wrapper. Accepts 32-bit IEEE-754
//   single products over a valid/ready handshake, tags each with its class,
//   buffers {class, product} in a first-word-fall-through FIFO and drains the
//   head over a second valid/ready port. Per-class saturating statistics are
//   kept for every accepted product; a one-cycle flush empties the FIFO
//   without touching the statistics.
//
// Parameters
//   DEPTH  FIFO entries (power of two, >= 2)
//   CNT_W  width of each statistics counter
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_data    product offered by the producer
//   in_ready            sink accepts this cycle
//   flush               discard buffered entries (honoured in RUN only)
//   out_valid           head entry available
//   out_data/out_class  head product and its class (0 zero, 1 denorm,
//                       2 normal, 3 inf, 4 NaN); undefined while !out_valid
//   out_ready           consumer takes the head
//   level               entries currently stored
//   cnt_*               saturating counts of accepted products

module fp_result_sink #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [31:0]                in_data,
    output logic                       in_ready,
    input  logic                       flush,
    output logic                       out_valid,
    output logic [31:0]                out_data,
    output logic [2:0]                 out_class,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic [CNT_W-1:0]           cnt_total,
    output logic [CNT_W-1:0]           cnt_nan,
    output logic [CNT_W-1:0]           cnt_inf,
    output logic [CNT_W-1:0]           cnt_zero,
    output logic [CNT_W-1:0]           cnt_denorm
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int ENT_W = 35;

    localparam logic [2:0] CLS_ZERO   = 3'd0;
    localparam logic [2:0] CLS_DENORM = 3'd1;
    localparam logic [2:0] CLS_NORMAL = 3'd2;
    localparam logic [2:0] CLS_INF    = 3'd3;
    localparam logic [2:0] CLS_NAN    = 3'd4;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // Sign bit is irrelevant to the class.
    function automatic logic [2:0] fp_class(input logic [31:0] d);
        logic [7:0]  e;
        logic [22:0] m;
        e = d[30:23];
        m = d[22:0];
        if (e == 8'h00)
            fp_class = (m == 23'd0) ? CLS_ZERO : CLS_DENORM;
        else if (e == 8'hFF)
            fp_class = (m == 23'd0) ? CLS_INF : CLS_NAN;
        else
            fp_class = CLS_NORMAL;
    endfunction

    // Counter increment that sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if (c == {CNT_W{1'b1}})
            sat_inc = c;
        else
            sat_inc = c + CNT_W'(1);
    endfunction

    state_t             state;
    state_t             state_nxt;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [ENT_W-1:0]   mem [DEPTH];
    logic [2:0]         in_class;
    logic               push;
    logic               pop;

    // Handshake decode
    assign in_ready  = (state == ST_RUN) && !flush && (level < LVL_W'(DEPTH));
    assign out_valid = (state == ST_RUN) && (level != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign in_class  = fp_class(in_data);

    // FWFT head: storage is read directly, no output register.
    assign out_data  = mem[rd_ptr][31:0];
    assign out_class = mem[rd_ptr][34:32];

    // Control state
    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_INIT;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT:  state_nxt = ST_RUN;
            ST_RUN:   if (flush) state_nxt = ST_FLUSH;
            ST_FLUSH: state_nxt = ST_RUN;
            default:  state_nxt = ST_INIT;
        endcase
    end

    // Pointers and occupancy; level is tracked separately from the pointers
    // so full and empty stay distinguishable.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (state == ST_FLUSH) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage (data only, never reset)
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {in_class, in_data};
    end

    // Statistics: count accepted products; flush leaves them alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_total  <= '0;
            cnt_nan    <= '0;
            cnt_inf    <= '0;
            cnt_zero   <= '0;
            cnt_denorm <= '0;
        end else if (push) begin
            cnt_total <= sat_inc(cnt_total);
            case (in_class)
                CLS_NAN:    cnt_nan    <= sat_inc(cnt_nan);
                CLS_INF:    cnt_inf    <= sat_inc(cnt_inf);
                CLS_ZERO:   cnt_zero   <= sat_inc(cnt_zero);
                CLS_DENORM: cnt_denorm <= sat_inc(cnt_denorm);
                default:    ;
            endcase
        end
    end

endmodule
